// File: rtl/interrupt_sequencer.sv
// ============================================================================
// interrupt_sequencer -- 6502 NMI/IRQ/BRK arbitration and 6-cycle entry sequence
// Revision 1.0
// ============================================================================
`default_nettype none

module interrupt_sequencer #(
  parameter logic [15:0] NMI_VEC    = 16'hFFFA,
  parameter logic [15:0] IRQ_VEC    = 16'hFFFE,
  parameter logic [7:0]  STACK_PAGE = 8'h01
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        nmi_n,
  input  logic        irq_n,
  input  logic [7:0]  p_in,
  input  logic [15:0] pc,
  input  logic [7:0]  sp,
  input  logic        boundary,
  input  logic        brk_req,
  input  logic [7:0]  mem_rdata,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  output logic        sp_dec,
  output logic [7:0]  flag_ena,
  output logic [7:0]  flag_d,
  output logic        pc_load,
  output logic [15:0] pc_new,
  output logic        busy,
  output logic [1:0]  int_kind,
  output logic        nmi_pend
);

  localparam logic [1:0] KIND_NONE = 2'd0;
  localparam logic [1:0] KIND_BRK  = 2'd1;
  localparam logic [1:0] KIND_IRQ  = 2'd2;
  localparam logic [1:0] KIND_NMI  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PUSH_PCH = 3'd1,
    S_PUSH_PCL = 3'd2,
    S_PUSH_P   = 3'd3,
    S_FETCH_LO = 3'd4,
    S_FETCH_HI = 3'd5,
    S_LOAD_PC  = 3'd6
  } state_t;

  state_t      state_q;
  logic        nmi_s1_q, nmi_s2_q, nmi_hist_q;
  logic        irq_s1_q, irq_s2_q;
  logic        nmi_pend_q, nmi_pend_d;
  logic [1:0]  kind_q;
  logic [15:0] ret_pc_q;
  logic [7:0]  vec_lo_q, vec_hi_q;
  logic        busy_q, we_q, re_q, sp_dec_q, set_i_q, pc_load_q;

  logic        nmi_edge, irq_req, entry;
  logic [1:0]  win_kind;
  logic [15:0] vec;

  assign nmi_edge = nmi_hist_q & ~nmi_s2_q;
  assign irq_req  = ~irq_s2_q & ~p_in[2];

  always_comb begin
    win_kind = KIND_NONE;
    if (nmi_pend_q)   win_kind = KIND_NMI;
    else if (irq_req) win_kind = KIND_IRQ;
    else if (brk_req) win_kind = KIND_BRK;
  end

  assign entry = (state_q == S_IDLE) && boundary && (win_kind != KIND_NONE);

  // A fresh edge in the same cycle as the NMI acknowledge must not be lost.
  always_comb begin
    nmi_pend_d = nmi_pend_q;
    if (nmi_edge)
      nmi_pend_d = 1'b1;
    else if (entry && (win_kind == KIND_NMI))
      nmi_pend_d = 1'b0;
  end

  assign vec = (kind_q == KIND_NMI) ? NMI_VEC : IRQ_VEC;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      nmi_s1_q   <= 1'b1;
      nmi_s2_q   <= 1'b1;
      nmi_hist_q <= 1'b1;
      irq_s1_q   <= 1'b1;
      irq_s2_q   <= 1'b1;
      nmi_pend_q <= 1'b0;
      kind_q     <= KIND_NONE;
      ret_pc_q   <= 16'h0000;
      vec_lo_q   <= 8'h00;
      vec_hi_q   <= 8'h00;
      busy_q     <= 1'b0;
      we_q       <= 1'b0;
      re_q       <= 1'b0;
      sp_dec_q   <= 1'b0;
      set_i_q    <= 1'b0;
      pc_load_q  <= 1'b0;
    end else begin
      nmi_s1_q   <= nmi_n;
      nmi_s2_q   <= nmi_s1_q;
      nmi_hist_q <= nmi_s2_q;
      irq_s1_q   <= irq_n;
      irq_s2_q   <= irq_s1_q;
      nmi_pend_q <= nmi_pend_d;

      busy_q    <= 1'b0;
      we_q      <= 1'b0;
      re_q      <= 1'b0;
      sp_dec_q  <= 1'b0;
      set_i_q   <= 1'b0;
      pc_load_q <= 1'b0;

      // Strobes are registered one state ahead so they line up with state_q.
      case (state_q)
        S_IDLE: begin
          if (entry) begin
            state_q  <= S_PUSH_PCH;
            kind_q   <= win_kind;
            ret_pc_q <= pc;
            busy_q   <= 1'b1;
            we_q     <= 1'b1;
            sp_dec_q <= 1'b1;
          end
        end
        S_PUSH_PCH: begin
          state_q  <= S_PUSH_PCL;
          busy_q   <= 1'b1;
          we_q     <= 1'b1;
          sp_dec_q <= 1'b1;
        end
        S_PUSH_PCL: begin
          state_q  <= S_PUSH_P;
          busy_q   <= 1'b1;
          we_q     <= 1'b1;
          sp_dec_q <= 1'b1;
          set_i_q  <= 1'b1;
        end
        S_PUSH_P: begin
          state_q <= S_FETCH_LO;
          busy_q  <= 1'b1;
          re_q    <= 1'b1;
        end
        S_FETCH_LO: begin
          state_q  <= S_FETCH_HI;
          vec_lo_q <= mem_rdata;
          busy_q   <= 1'b1;
          re_q     <= 1'b1;
        end
        S_FETCH_HI: begin
          state_q   <= S_LOAD_PC;
          vec_hi_q  <= mem_rdata;
          busy_q    <= 1'b1;
          pc_load_q <= 1'b1;
        end
        S_LOAD_PC: begin
          state_q <= S_IDLE;
          kind_q  <= KIND_NONE;
        end
        default: begin
          state_q <= S_IDLE;
          kind_q  <= KIND_NONE;
        end
      endcase
    end
  end

  // Stack pointer and status byte are forwarded live from the core.
  always_comb begin
    mem_addr  = 16'h0000;
    mem_wdata = 8'h00;
    case (state_q)
      S_PUSH_PCH: begin
        mem_addr  = {STACK_PAGE, sp};
        mem_wdata = ret_pc_q[15:8];
      end
      S_PUSH_PCL: begin
        mem_addr  = {STACK_PAGE, sp};
        mem_wdata = ret_pc_q[7:0];
      end
      S_PUSH_P: begin
        mem_addr  = {STACK_PAGE, sp};
        mem_wdata = {p_in[7:6], 1'b1, (kind_q == KIND_BRK), p_in[3:0]};
      end
      S_FETCH_LO: mem_addr = vec;
      S_FETCH_HI: mem_addr = vec + 16'd1;
      default: begin
        mem_addr  = 16'h0000;
        mem_wdata = 8'h00;
      end
    endcase
  end

  assign mem_we   = we_q;
  assign mem_re   = re_q;
  assign sp_dec   = sp_dec_q;
  assign flag_ena = {5'b00000, set_i_q, 2'b00};
  assign flag_d   = {5'b00000, set_i_q, 2'b00};
  assign pc_load  = pc_load_q;
  assign pc_new   = pc_load_q ? {vec_hi_q, vec_lo_q} : 16'h0000;
  assign busy     = busy_q;
  assign int_kind = kind_q;
  assign nmi_pend = nmi_pend_q;

endmodule

`default_nettype wire

// File: tb/tb_interrupt_sequencer.sv
// ============================================================================
// tb_interrupt_sequencer -- directed bench with a step-level reference model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_interrupt_sequencer;

  logic        clk = 1'b0;
  logic        reset, nmi_n, irq_n, boundary, brk_req;
  logic [7:0]  p_in, sp, mem_rdata;
  logic [15:0] pc;
  logic [15:0] mem_addr, pc_new;
  logic [7:0]  mem_wdata, flag_ena, flag_d;
  logic        mem_we, mem_re, sp_dec, pc_load, busy, nmi_pend;
  logic [1:0]  int_kind;

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_rd(input logic [15:0] a);
    case (a)
      16'hFFFA: return 8'h34;
      16'hFFFB: return 8'hC2;
      16'hFFFE: return 8'h00;
      16'hFFFF: return 8'h80;
      default:  return 8'h00;
    endcase
  endfunction

  assign mem_rdata = mem_rd(mem_addr);

  interrupt_sequencer dut (
    .clk(clk), .reset(reset), .nmi_n(nmi_n), .irq_n(irq_n), .p_in(p_in),
    .pc(pc), .sp(sp), .boundary(boundary), .brk_req(brk_req),
    .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_re(mem_re), .sp_dec(sp_dec), .flag_ena(flag_ena),
    .flag_d(flag_d), .pc_load(pc_load), .pc_new(pc_new), .busy(busy),
    .int_kind(int_kind), .nmi_pend(nmi_pend)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
  endtask

  // Reference model: step 0 is idle, steps 1..6 are the busy cycles of an entry.
  int          m_step = 0;
  logic [1:0]  m_kind;
  logic [15:0] m_ret;
  logic [7:0]  m_sp, m_p;
  logic        m_pend;
  logic [2:0]  m_nh;   // [0] = nmi_n one edge ago, [1] two ago, [2] three ago
  logic [1:0]  m_ih;
  bit          m_valid = 0;

  logic        c_reset, c_nmi, c_irq, c_bnd, c_brk;
  logic [7:0]  c_p, c_sp;
  logic [15:0] c_pc;

  task automatic model_update();
    logic       fall, irq;
    logic [1:0] k;
    logic       clr;
    if (!c_reset) begin
      m_step = 0; m_kind = 2'd0; m_pend = 1'b0;
      m_nh = 3'b111; m_ih = 2'b11; m_valid = 1;
    end else if (m_valid) begin
      fall = (m_nh[1] == 1'b0) && (m_nh[2] == 1'b1);
      irq  = (m_ih[1] == 1'b0) && !c_p[2];
      clr  = 1'b0;
      if (m_step == 0) begin
        if (c_bnd) begin
          k = m_pend ? 2'd3 : irq ? 2'd2 : c_brk ? 2'd1 : 2'd0;
          if (k != 2'd0) begin
            m_step = 1; m_kind = k; m_ret = c_pc; m_sp = c_sp; m_p = c_p;
            clr = (k == 2'd3);
          end
        end
      end else if (m_step == 6) begin
        m_step = 0; m_kind = 2'd0;
      end else begin
        m_step++;
      end
      m_pend = fall ? 1'b1 : (clr ? 1'b0 : m_pend);
      m_nh = {m_nh[1:0], c_nmi};
      m_ih = {m_ih[0], c_irq};
    end
  endtask

  task automatic check_outputs();
    logic [15:0] v, e_addr, e_pcnew;
    logic [7:0]  e_wd, e_f;
    logic [1:0]  e_kind;
    int s;
    s = m_step;
    v = (m_kind == 2'd3) ? 16'hFFFA : 16'hFFFE;
    e_addr = 16'h0000; e_wd = 8'h00;
    if (s >= 1 && s <= 3) e_addr = {8'h01, 8'(m_sp - 8'(s - 1))};
    if (s == 4) e_addr = v;
    if (s == 5) e_addr = v + 16'd1;
    if (s == 1) e_wd = m_ret[15:8];
    if (s == 2) e_wd = m_ret[7:0];
    if (s == 3) e_wd = {m_p[7:6], 1'b1, (m_kind == 2'd1), m_p[3:0]};
    e_f     = (s == 3) ? 8'h04 : 8'h00;
    e_pcnew = (s == 6) ? {mem_rd(v + 16'd1), mem_rd(v)} : 16'h0000;
    e_kind  = (s != 0) ? m_kind : 2'd0;
    chk("busy",      32'(busy),      32'(s != 0));
    chk("mem_we",    32'(mem_we),    32'(s >= 1 && s <= 3));
    chk("sp_dec",    32'(sp_dec),    32'(s >= 1 && s <= 3));
    chk("mem_re",    32'(mem_re),    32'(s == 4 || s == 5));
    chk("mem_addr",  32'(mem_addr),  32'(e_addr));
    chk("mem_wdata", 32'(mem_wdata), 32'(e_wd));
    chk("flag_ena",  32'(flag_ena),  32'(e_f));
    chk("flag_d",    32'(flag_d),    32'(e_f));
    chk("pc_load",   32'(pc_load),   32'(s == 6));
    chk("pc_new",    32'(pc_new),    32'(e_pcnew));
    chk("int_kind",  32'(int_kind),  32'(e_kind));
    chk("nmi_pend",  32'(nmi_pend),  32'(m_pend));
  endtask

  // Observation logs for the hand-computed expectations.
  logic [15:0] wlog_a[$];
  logic [7:0]  wlog_d[$];
  logic [15:0] rlog_a[$];
  int          busy_cnt, flag_at, load_at, load_cnt;
  logic [15:0] last_pc_new;
  logic [1:0]  first_kind;

  task automatic clear_logs();
    wlog_a.delete(); wlog_d.delete(); rlog_a.delete();
    busy_cnt = 0; flag_at = 0; load_at = 0; load_cnt = 0;
    last_pc_new = 16'h0000; first_kind = 2'd0;
  endtask

  task automatic tick();
    logic       cap_dec, was_valid;
    logic [7:0] cap_fe, cap_fd;
    #1;
    was_valid = m_valid;
    if (m_valid) begin
      check_outputs();
      if (busy) busy_cnt++;
      if (busy && busy_cnt == 1) first_kind = int_kind;
      if (mem_we) begin wlog_a.push_back(mem_addr); wlog_d.push_back(mem_wdata); end
      if (mem_re) rlog_a.push_back(mem_addr);
      if (flag_ena == 8'h04) flag_at = busy_cnt;
      if (pc_load) begin load_cnt++; load_at = busy_cnt; last_pc_new = pc_new; end
    end
    c_reset = reset; c_nmi = nmi_n; c_irq = irq_n; c_bnd = boundary;
    c_brk = brk_req; c_p = p_in; c_sp = sp; c_pc = pc;
    cap_dec = sp_dec; cap_fe = flag_ena; cap_fd = flag_d;
    @(posedge clk);
    model_update();
    #1;
    if (was_valid) begin
      if (cap_dec === 1'b1) sp = sp - 8'd1;
      p_in = (p_in & ~cap_fe) | (cap_fd & cap_fe);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic entry_pulse(input logic brk);
    boundary = 1'b1; brk_req = brk;
    tick();
    boundary = 1'b0; brk_req = 1'b0;
  endtask

  initial begin
    reset = 1'b0; nmi_n = 1'b1; irq_n = 1'b1; boundary = 1'b0; brk_req = 1'b0;
    p_in = 8'h00; sp = 8'hFF; pc = 16'h0000;
    clear_logs();
    ticks(2);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset int_kind", 32'(int_kind), 32'd0);
    chk("reset mem_addr", 32'(mem_addr), 32'd0);
    reset = 1'b1;
    ticks(2);

    // BRK entry
    p_in = 8'h00; pc = 16'h1236; sp = 8'hFD;
    clear_logs();
    entry_pulse(1'b1);
    ticks(7);
    chk("brk writes", 32'(wlog_a.size()), 32'd3);
    chk("brk w0 addr", 32'(wlog_a[0]), 32'h01FD);
    chk("brk w0 data", 32'(wlog_d[0]), 32'h12);
    chk("brk w1 addr", 32'(wlog_a[1]), 32'h01FC);
    chk("brk w1 data", 32'(wlog_d[1]), 32'h36);
    chk("brk w2 addr", 32'(wlog_a[2]), 32'h01FB);
    chk("brk w2 data", 32'(wlog_d[2]), 32'h30);
    chk("brk flag cycle", 32'(flag_at), 32'd3);
    chk("brk load cycle", 32'(load_at), 32'd6);
    chk("brk pc_new", 32'(last_pc_new), 32'h8000);
    chk("brk busy cycles", 32'(busy_cnt), 32'd6);
    chk("brk kind", 32'(first_kind), 32'd1);

    // IRQ masked, then unmasked
    irq_n = 1'b0; p_in = 8'h04;
    clear_logs();
    for (int i = 0; i < 3; i++) begin
      entry_pulse(1'b0);
      ticks(2);
    end
    chk("irq masked busy", 32'(busy_cnt), 32'd0);
    p_in = 8'h00; pc = 16'h2000;
    clear_logs();
    entry_pulse(1'b0);
    ticks(7);
    chk("irq kind", 32'(first_kind), 32'd2);
    chk("irq pushed P", 32'(wlog_d[2]), 32'h20);
    chk("irq pc_new", 32'(last_pc_new), 32'h8000);
    irq_n = 1'b1;
    ticks(3);

    // NMI edge, latch and single service while held low
    clear_logs();
    nmi_n = 1'b0;
    tick(); chk("nmi pend edge1", 32'(nmi_pend), 32'd0);
    tick(); chk("nmi pend edge2", 32'(nmi_pend), 32'd0);
    tick(); chk("nmi pend edge3", 32'(nmi_pend), 32'd1);
    pc = 16'h4000;
    entry_pulse(1'b0);
    ticks(7);
    chk("nmi kind", 32'(first_kind), 32'd3);
    chk("nmi read lo", 32'(rlog_a[0]), 32'hFFFA);
    chk("nmi read hi", 32'(rlog_a[1]), 32'hFFFB);
    chk("nmi pc_new", 32'(last_pc_new), 32'hC234);
    chk("nmi pend cleared", 32'(nmi_pend), 32'd0);
    clear_logs();
    entry_pulse(1'b0); tick();
    entry_pulse(1'b0); ticks(2);
    chk("nmi held no retrigger", 32'(busy_cnt), 32'd0);
    nmi_n = 1'b1;
    ticks(3);

    // Priority: NMI over IRQ over BRK, IRQ served at the following boundary
    p_in = 8'h00; irq_n = 1'b0; nmi_n = 1'b0; pc = 16'h3000;
    ticks(3);
    clear_logs();
    entry_pulse(1'b1);
    ticks(7);
    chk("prio first kind", 32'(first_kind), 32'd3);
    p_in = 8'h00;
    clear_logs();
    entry_pulse(1'b0);
    ticks(7);
    chk("prio second kind", 32'(first_kind), 32'd2);
    irq_n = 1'b1; nmi_n = 1'b1;
    ticks(4);

    // Reset during PUSH_PCL
    p_in = 8'h00; sp = 8'hF0; pc = 16'h5555;
    nmi_n = 1'b0;
    tick();
    entry_pulse(1'b1);
    tick();
    chk("pre-reset busy", 32'(busy), 32'd1);
    chk("pre-reset nmi_pend", 32'(nmi_pend), 32'd1);
    reset = 1'b0;
    tick();
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort mem_we", 32'(mem_we), 32'd0);
    chk("abort sp_dec", 32'(sp_dec), 32'd0);
    chk("abort nmi_pend", 32'(nmi_pend), 32'd0);
    chk("abort int_kind", 32'(int_kind), 32'd0);
    reset = 1'b1; nmi_n = 1'b1;
    ticks(3);

    // Stack page wrap
    p_in = 8'h00; sp = 8'h00; pc = 16'hABCD;
    clear_logs();
    entry_pulse(1'b1);
    ticks(7);
    chk("wrap w0 addr", 32'(wlog_a[0]), 32'h0100);
    chk("wrap w1 addr", 32'(wlog_a[1]), 32'h01FF);
    chk("wrap w2 addr", 32'(wlog_a[2]), 32'h01FE);
    chk("wrap pc_new", 32'(last_pc_new), 32'h8000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/interrupt_sequencer.md
Name: interrupt_sequencer

Overview:
- Interrupt/BRK entry sequencer for the 6502 core; sits directly downstream of the processor status (flag) register.
- Consumes the current status byte, including the I mask bit, and arbitrates NMI, IRQ and BRK at instruction boundaries.
- Runs the 6-cycle entry sequence: push PCH, PCL and P; fetch the vector; load PC.
- Drives the flag register's per-bit enable/data inputs to set I during entry.

Parameters:
- NMI_VEC, 16'hFFFA, NMI vector low-byte address.
- IRQ_VEC, 16'hFFFE, IRQ/BRK vector low-byte address.
- STACK_PAGE, 8'h01, high byte of stack addresses.

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- nmi_n  in  1  NMI pin, asynchronous, falling-edge triggered.
- irq_n  in  1  IRQ pin, asynchronous, level, active-low.
- p_in  in  8  current status byte from the flag register q.
- pc  in  16  return address from the core (BRK: already PC+2).
- sp  in  8  current stack pointer.
- boundary  in  1  core at last cycle of an instruction.
- brk_req  in  1  decoded BRK opcode, valid with boundary.
- mem_rdata  in  8  read data, valid in the same cycle as mem_re.
- mem_addr  out  16  bus address.
- mem_wdata  out  8  bus write data.
- mem_we  out  1  write strobe.
- mem_re  out  1  read strobe.
- sp_dec  out  1  decrement stack pointer at end of cycle.
- flag_ena  out  8  per-bit enable to the flag register.
- flag_d  out  8  data to the flag register.
- pc_load  out  1  load pc_new into PC.
- pc_new  out  16  vector target.
- busy  out  1  sequence active; core stalls.
- int_kind  out  2  0 none, 1 BRK, 2 IRQ, 3 NMI.
- nmi_pend  out  1  latched NMI request.

Behaviour:
- Reset (reset==0 at a rising edge):
  - State goes to IDLE; sync flops preset to 1; nmi_pend cleared.
  - All outputs are 0: busy, mem_we, mem_re, sp_dec, flag_ena, flag_d, pc_load, pc_new, mem_addr, mem_wdata, int_kind.
  - Reset mid-sequence aborts immediately; partial pushes are not undone.
- NMI synchronisation and latch:
  - nmi_n passes through 2 sync flops plus a history flop. The edge is history==1 and sync==0.
  - nmi_pend sets at the 3rd rising edge after nmi_n is first sampled low.
  - nmi_pend clears only at sequence entry with kind NMI. If a new edge arrives in the same cycle as the clear, set wins.
  - A held-low nmi_n produces exactly one request.
- IRQ: irq_n uses a 2-flop sync. irq_req = ~irq_sync & ~p_in[2]; it is level-sensitive and not latched.
- Arbitration: performed only in IDLE with boundary==1. Priority is NMI > IRQ > BRK.
  - The winner is latched into int_kind.
  - pc is latched as ret_pc.
  - B = 1 only for BRK.
  - If nothing wins, stay in IDLE.
  - Requests arriving while busy wait for the next boundary.
- States (one cycle each, busy=1 in all except IDLE):
  - PUSH_PCH: mem_addr={STACK_PAGE,sp}, mem_wdata=ret_pc[15:8], mem_we=1, sp_dec=1.
  - PUSH_PCL: same address form, mem_wdata=ret_pc[7:0], mem_we=1, sp_dec=1.
  - PUSH_P: mem_wdata = p_in with bit5=1 and bit4=B; mem_we=1, sp_dec=1; flag_ena=8'h04, flag_d=8'h04 (sets I; D untouched).
  - FETCH_LO: mem_addr=vec (NMI_VEC if kind 3, else IRQ_VEC), mem_re=1; mem_rdata latched as vec_lo.
  - FETCH_HI: mem_addr=vec+1, mem_re=1; mem_rdata latched as vec_hi.
  - LOAD_PC: pc_load=1, pc_new={vec_hi,vec_lo}; next state IDLE; int_kind cleared to 0 on that edge.
- Timing: the entry edge is followed by exactly 6 busy cycles. Strobes are 0 in IDLE.
- Combinational paths: sp and p_in pass combinationally to mem_addr/mem_wdata. All other outputs decode from registered state and latches.
- Stack address wraps within the page: sp=8'h00 gives 16'h0100, and the external decrement wraps sp to 8'hFF.

Test Plan:
- BRK: p_in=8'h00, pc=16'h1236, sp=8'hFD, brk_req+boundary; mem_rdata FE→8'h00, FF→8'h80.
  - Required writes: 0x01FD←12, 0x01FC←36, 0x01FB←30.
  - Required: flag_ena=04 in cycle 3; pc_new=16'h8000 with pc_load in cycle 6; busy high for exactly 6 cycles.
- IRQ masked: irq_n=0 with p_in[2]=1 over several boundaries → stays IDLE. Clear p_in[2] → IRQ entry at next boundary; pushed P has bit4=0, bit5=1.
- NMI edge: nmi_n falls and stays low → nmi_pend after 3 edges. One sequence using addresses FFFA/FFFB. No second sequence while nmi_n stays low.
- Priority: NMI pending, irq_n=0, I=0 and brk_req all at one boundary → int_kind=3. IRQ is serviced at the following boundary.
- Reset mid-sequence: reset=0 during PUSH_PCL → next cycle IDLE, busy=0, all strobes 0, nmi_pend=0.
- Wrap: sp=8'h00 at entry → first push to 16'h0100.
